// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-memory request path (initiator and responder).
package mem_if_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MEM_AW    = 11;
    localparam logic [31:0] BASE_ADDR = 32'd1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } mem_state_t;

    // True when a base-relative byte offset lands inside a 2**aw word memory.
    function automatic logic word_in_range(input logic [31:0] off, input int unsigned aw);
        return (off >> (aw + 32'd2)) == 32'd0;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Cycle counter bounding how long one memory access may stay outstanding.
module mem_wait_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count;

    // Count enabled cycles from the last clear; hold once the limit is hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 8'd1;
        end
    end

    // High during the LIMIT-th enabled cycle after a clear.
    assign expired = (count == 8'(LIMIT - 1));

endmodule

// File: rtl/mem_req_master.sv
// MEM-stage initiator: turns held load/store enables into one valid/ready
// request to word-addressed data memory, stalling the pipeline until done.
module mem_req_master #(
    parameter int unsigned DATA_W    = mem_if_pkg::DATA_W,
    parameter int unsigned MEM_AW    = mem_if_pkg::MEM_AW,
    parameter logic [31:0] BASE_ADDR = mem_if_pkg::BASE_ADDR,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              freeze,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              err,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_we,
    output logic [MEM_AW-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              s_rvalid,
    input  logic [DATA_W-1:0] s_rdata
);

    import mem_if_pkg::*;

    mem_state_t  state;
    logic [31:0] off;
    logic        legal;
    logic        start;
    logic        bad_req;
    logic        accept;
    logic        resp;
    logic        abort;
    logic        expired;

    assign off     = req_addr - BASE_ADDR;
    assign legal   = (req_addr[1:0] == 2'b00) && word_in_range(off, MEM_AW);
    assign start   = (state == IDLE) && (req_rd ^ req_wr) && legal;
    assign bad_req = (state == IDLE) && (req_rd || req_wr) && !((req_rd ^ req_wr) && legal);
    assign m_valid = (state == ISSUE);
    assign accept  = m_valid && m_ready;
    assign resp    = (state == WAIT) && s_rvalid;
    // A read handshake on the last allowed cycle is not a completion, so it aborts too.
    assign abort   = expired && (((state == ISSUE) && !(accept && m_we)) ||
                                 ((state == WAIT) && !s_rvalid));
    assign freeze  = (state == ISSUE) || (state == WAIT) || start;

    mem_wait_timer #(
        .LIMIT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (start),
        .en     ((state == ISSUE) || (state == WAIT)),
        .expired(expired)
    );

    // Access sequencing; the request fields are captured once and held while issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            m_addr  <= '0;
            m_wdata <= '0;
            m_we    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ISSUE;
                        m_addr  <= off[MEM_AW+1:2];
                        m_wdata <= req_wdata;
                        m_we    <= req_wr;
                    end
                end
                ISSUE: begin
                    if (accept && m_we) begin
                        state <= DONE;
                    end else if (expired) begin
                        state <= DONE;
                    end else if (accept) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (s_rvalid || expired) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Registered completion and error pulses plus the held load result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            rd_valid <= resp;
            err      <= bad_req || abort;
            if (resp) begin
                rd_data <= s_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_master.sv
// Self-checking bench for mem_req_master: directed vector table, randomized
// transactions against a transaction-level model, timeout and reset sequences.
module tb_mem_req_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_rd = 1'b0, req_wr = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        m_ready = 1'b0, s_rvalid = 1'b0;
    logic [31:0] s_rdata = '0;
    logic        sel = 1'b0;

    logic        a_freeze, a_rd_valid, a_err, a_m_valid, a_m_we;
    logic [31:0] a_rd_data, a_m_wdata;
    logic [10:0] a_m_addr;
    logic        b_freeze, b_rd_valid, b_err, b_m_valid, b_m_we;
    logic [31:0] b_rd_data, b_m_wdata;
    logic [10:0] b_m_addr;

    logic        freeze, rd_valid, err, m_valid, m_we;
    logic [31:0] rd_data, m_wdata;
    logic [10:0] m_addr;

    always #5 clk = ~clk;

    mem_req_master #(.DATA_W(32), .MEM_AW(11), .BASE_ADDR(32'd1024), .TIMEOUT(255)) dut_a (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .freeze(a_freeze), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .err(a_err), .m_valid(a_m_valid), .m_ready(m_ready), .m_we(a_m_we), .m_addr(a_m_addr),
        .m_wdata(a_m_wdata), .s_rvalid(s_rvalid), .s_rdata(s_rdata));

    mem_req_master #(.DATA_W(32), .MEM_AW(11), .BASE_ADDR(32'd1024), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .freeze(b_freeze), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .err(b_err), .m_valid(b_m_valid), .m_ready(m_ready), .m_we(b_m_we), .m_addr(b_m_addr),
        .m_wdata(b_m_wdata), .s_rvalid(s_rvalid), .s_rdata(s_rdata));

    assign freeze   = sel ? b_freeze   : a_freeze;
    assign rd_valid = sel ? b_rd_valid : a_rd_valid;
    assign err      = sel ? b_err      : a_err;
    assign m_valid  = sel ? b_m_valid  : a_m_valid;
    assign m_we     = sel ? b_m_we     : a_m_we;
    assign rd_data  = sel ? b_rd_data  : a_rd_data;
    assign m_wdata  = sel ? b_m_wdata  : a_m_wdata;
    assign m_addr   = sel ? b_m_addr   : a_m_addr;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [31:0] resp_mem  [int unsigned];
    logic [31:0] model_mem [int unsigned];
    logic [31:0] last_rd = '0;

    typedef struct {
        int unsigned err_n, fz_n, hs_n, rv_n, mv_n, bad_n, ovl_n;
        bit          hung;
        logic [10:0] first_addr;
        logic        first_we;
        logic [31:0] first_wdata;
    } res_t;

    typedef struct {
        logic        rd, wr;
        logic [31:0] addr, wdata;
        int unsigned rdly, vdly;
        logic        exp_err;
        int unsigned exp_fz;
        logic        exp_rv;
        logic [31:0] exp_rdata;
        logic [10:0] exp_word;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    function automatic bit m_legal(input logic [31:0] a);
        longint x;
        x = longint'(a);
        return (x % 4 == 0) && (x >= 1024) && ((x - 1024) / 4 < 2048);
    endfunction

    function automatic int unsigned m_idx(input logic [31:0] a);
        return (a - 32'd1024) / 4;
    endfunction

    function automatic logic [31:0] model_rd(input int unsigned i);
        return model_mem.exists(i) ? model_mem[i] : 32'h0;
    endfunction

    function automatic logic [31:0] resp_rd(input int unsigned i);
        return resp_mem.exists(i) ? resp_mem[i] : 32'h0;
    endfunction

    // Drives one held request, plays the memory side (ready after rdly cycles of
    // m_valid, response vdly cycles after accept; vdly 0 = never responds).
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int unsigned rdly,
                           input int unsigned vdly, output res_t r);
        int unsigned cd, after;
        bit drop;
        logic [31:0] rdq;
        r = '{default: 0};
        r.hung = 1'b1;
        cd = 0; after = 0; drop = 1'b0; rdq = '0;
        @(negedge clk);
        req_rd = rd; req_wr = wr; req_addr = addr; req_wdata = wdata;
        for (int c = 0; c < 400; c++) begin
            if (drop) begin req_rd = 1'b0; req_wr = 1'b0; end
            m_ready = 1'b0;
            s_rvalid = 1'b0;
            if (cd != 0) begin
                cd--;
                if (cd == 0) begin s_rvalid = 1'b1; s_rdata = rdq; end
            end
            #1;
            if (freeze) r.fz_n++;
            if (err) r.err_n++;
            if (rd_valid) r.rv_n++;
            if (m_valid && (err || rd_valid)) r.ovl_n++;
            if (err && rd_valid) r.ovl_n++;
            if (m_valid) begin
                if (r.mv_n == 0) begin
                    r.first_addr = m_addr; r.first_we = m_we; r.first_wdata = m_wdata;
                end else if (m_addr !== r.first_addr || m_we !== r.first_we ||
                             m_wdata !== r.first_wdata) begin
                    r.bad_n++;
                end
                if (r.mv_n == rdly) begin
                    m_ready = 1'b1;
                    r.hs_n++;
                    if (m_we) resp_mem[m_addr] = m_wdata;
                    else if (vdly != 0) begin cd = vdly; rdq = resp_rd(m_addr); end
                end
                r.mv_n++;
            end
            if (drop) after++;
            if (after == 3) begin r.hung = 1'b0; break; end
            if (!freeze && !drop) drop = 1'b1;
            @(negedge clk);
        end
        req_rd = 1'b0; req_wr = 1'b0; m_ready = 1'b0; s_rvalid = 1'b0;
    endtask

    task automatic check_proto(input string tag, input res_t r);
        check({tag, "_protocol"}, r.bad_n + r.ovl_n + int'(r.hung), 32'd0);
    endtask

    vec_t vecs[11];
    res_t r;

    initial begin
        // Directed vectors, applied in order on the default-timeout instance.
        vecs[0]  = '{1'b0, 1'b1, 32'h400,  32'hDEADBEEF, 0, 1, 1'b0, 2,  1'b0, 32'h0,        11'd0};
        vecs[1]  = '{1'b1, 1'b0, 32'h404,  32'h0,        0, 3, 1'b0, 5,  1'b1, 32'h12345678, 11'd1};
        vecs[2]  = '{1'b1, 1'b0, 32'h400,  32'h0,        0, 1, 1'b0, 3,  1'b1, 32'hDEADBEEF, 11'd0};
        vecs[3]  = '{1'b1, 1'b0, 32'h402,  32'h0,        0, 1, 1'b1, 0,  1'b0, 32'hDEADBEEF, 11'd0};
        vecs[4]  = '{1'b1, 1'b0, 32'h3FC,  32'h0,        0, 1, 1'b1, 0,  1'b0, 32'hDEADBEEF, 11'd0};
        vecs[5]  = '{1'b1, 1'b0, 32'h2400, 32'h0,        0, 1, 1'b1, 0,  1'b0, 32'hDEADBEEF, 11'd0};
        vecs[6]  = '{1'b1, 1'b1, 32'h400,  32'h1,        0, 1, 1'b1, 0,  1'b0, 32'hDEADBEEF, 11'd0};
        vecs[7]  = '{1'b0, 1'b1, 32'h408,  32'hA5A50001, 8, 1, 1'b0, 10, 1'b0, 32'hDEADBEEF, 11'd2};
        vecs[8]  = '{1'b0, 1'b1, 32'h23FC, 32'h0BADF00D, 0, 1, 1'b0, 2,  1'b0, 32'hDEADBEEF, 11'd2047};
        vecs[9]  = '{1'b1, 1'b0, 32'h23FC, 32'h0,        2, 2, 1'b0, 6,  1'b1, 32'h0BADF00D, 11'd2047};
        vecs[10] = '{1'b0, 1'b0, 32'h400,  32'h0,        0, 1, 1'b0, 0,  1'b0, 32'h0BADF00D, 11'd0};

        resp_mem[1]  = 32'h12345678;
        model_mem[1] = 32'h12345678;

        repeat (2) @(negedge clk);
        #1;
        check("reset_freeze", freeze, 0);
        check("reset_pulses", {rd_valid, err, m_valid, m_we}, 0);
        check("reset_m_addr", m_addr, 0);
        check("reset_m_wdata", m_wdata, 0);
        check("reset_rd_data", rd_data, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int unsigned i = 0; i < 11; i++) begin
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                    vecs[i].rdly, vecs[i].vdly, r);
            check($sformatf("vec%0d_err", i), r.err_n, vecs[i].exp_err);
            check($sformatf("vec%0d_freeze", i), r.fz_n, vecs[i].exp_fz);
            check($sformatf("vec%0d_rd_valid", i), r.rv_n, vecs[i].exp_rv);
            check($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp_rdata);
            check($sformatf("vec%0d_handshakes", i), r.hs_n, (vecs[i].exp_fz != 0) ? 1 : 0);
            check_proto($sformatf("vec%0d", i), r);
            if (vecs[i].exp_fz != 0) begin
                check($sformatf("vec%0d_m_addr", i), r.first_addr, vecs[i].exp_word);
                check($sformatf("vec%0d_m_we", i), r.first_we, vecs[i].wr);
                if (vecs[i].wr) begin
                    check($sformatf("vec%0d_m_wdata", i), r.first_wdata, vecs[i].wdata);
                    model_mem[m_idx(vecs[i].addr)] = vecs[i].wdata;
                end
            end
        end
        last_rd = rd_data;

        // Randomized transactions checked against the transaction-level model.
        for (int unsigned t = 0; t < 60; t++) begin
            logic        rd, wr, go;
            logic [31:0] addr, wdata, exp_rdata;
            int unsigned kind, rdly, vdly, exp_fz;
            kind = $urandom_range(0, 3);
            rd = (kind == 1) || (kind == 3) || (kind == 0 && $urandom_range(0, 1) == 1);
            wr = (kind == 2) || (kind == 3);
            case ($urandom_range(0, 9))
                0, 1, 2: addr = 32'd1024 + 4 * $urandom_range(0, 2047);
                3, 4, 5, 6: addr = 32'd1024 + 4 * $urandom_range(0, 7);
                7: addr = 32'd1024 + 4 * $urandom_range(0, 2047) + $urandom_range(1, 3);
                8: addr = 4 * $urandom_range(0, 255);
                default: addr = 32'd1024 + 32'd8192 + 4 * $urandom_range(0, 1000);
            endcase
            wdata = $urandom;
            rdly = $urandom_range(0, 3);
            vdly = $urandom_range(1, 4);
            go = (rd ^ wr) && m_legal(addr);
            exp_fz = go ? (wr ? rdly + 2 : rdly + 2 + vdly) : 0;
            exp_rdata = (go && rd) ? model_rd(m_idx(addr)) : last_rd;
            run_txn(rd, wr, addr, wdata, rdly, vdly, r);
            check($sformatf("rnd%0d_err", t), r.err_n, ((rd || wr) && !go) ? 1 : 0);
            check($sformatf("rnd%0d_freeze", t), r.fz_n, exp_fz);
            check($sformatf("rnd%0d_rd_valid", t), r.rv_n, (go && rd) ? 1 : 0);
            check($sformatf("rnd%0d_rd_data", t), rd_data, exp_rdata);
            check($sformatf("rnd%0d_handshakes", t), r.hs_n, go ? 1 : 0);
            check_proto($sformatf("rnd%0d", t), r);
            if (go) begin
                check($sformatf("rnd%0d_m_addr", t), r.first_addr, m_idx(addr));
                check($sformatf("rnd%0d_m_we", t), r.first_we, wr);
                if (wr) begin
                    check($sformatf("rnd%0d_m_wdata", t), r.first_wdata, wdata);
                    model_mem[m_idx(addr)] = wdata;
                end
            end
            last_rd = exp_rdata;
        end

        // Timeout behaviour on the TIMEOUT=4 instance.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        sel = 1'b1;
        run_txn(1'b1, 1'b0, 32'h404, 32'h0, 0, 2, r);
        check("to_prime_rd_data", rd_data, model_rd(1));
        check("to_prime_rd_valid", r.rv_n, 1);
        run_txn(1'b1, 1'b0, 32'h404, 32'h0, 0, 0, r);
        check("to_load_err", r.err_n, 1);
        check("to_load_freeze", r.fz_n, 5);
        check("to_load_rd_valid", r.rv_n, 0);
        check("to_load_rd_data", rd_data, model_rd(1));
        check_proto("to_load", r);
        run_txn(1'b0, 1'b1, 32'h408, 32'h55, 99, 1, r);
        check("to_store_err", r.err_n, 1);
        check("to_store_freeze", r.fz_n, 5);
        check("to_store_m_valid_cycles", r.mv_n, 4);
        check("to_store_handshakes", r.hs_n, 0);
        @(negedge clk); s_rvalid = 1'b1; s_rdata = 32'hFFFF0000;
        @(negedge clk); s_rvalid = 1'b0;
        #1 check("stray_rd_valid", rd_valid, 0);
        @(negedge clk);
        #1 check("stray_rd_data", rd_data, model_rd(1));

        // Reset asserted while a load waits for its response.
        sel = 1'b0;
        @(negedge clk); req_rd = 1'b1; req_addr = 32'h404;
        @(negedge clk);
        #1 check("rst_seq_issue", m_valid, 1);
        m_ready = 1'b1;
        @(negedge clk); m_ready = 1'b0;
        #1 check("rst_seq_wait", {freeze, m_valid}, 2'b10);
        #2 rst = 1'b1; req_rd = 1'b0;
        #1;
        check("rst_async_ctrl", {freeze, m_valid, m_we, rd_valid, err}, 0);
        check("rst_async_m_addr", m_addr, 0);
        check("rst_async_rd_data", rd_data, 0);
        @(negedge clk); rst = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h77777777;
        @(negedge clk); s_rvalid = 1'b0;
        #1 check("late_rvalid_ignored", {rd_valid, rd_data}, 0);
        run_txn(1'b1, 1'b0, 32'h404, 32'h0, 0, 2, r);
        check("post_rst_freeze", r.fz_n, 4);
        check("post_rst_rd_valid", r.rv_n, 1);
        check("post_rst_rd_data", rd_data, model_rd(1));
        check_proto("post_rst", r);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
